// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and {CPOL, CPHA} mode values.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spiState_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // CPHA=1 modes shift data on the leading edge and sample on the trailing edge.
    function automatic logic modeCpha(input logic [1:0] mode);
        return (mode == MODE1) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Edge-rate divider: emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_tick
);

    logic [7:0] r_count;
    logic       w_wrap;

    assign w_wrap = (r_count == 8'(CLK_DIV - 1));
    assign o_tick = i_enable && w_wrap;

    // Held at zero while disabled so every transfer starts with a full SETUP period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_enable || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: one word per transfer, selectable mode, bit order and chip select.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int CLK_DIV   = 2,
    parameter  int NUM_CS    = 1,
    parameter  int LSB_FIRST = 1,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    spiState_t         r_state;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_txShift;
    logic [DATA_W-1:0] r_rxShift;
    logic [EW-1:0]     r_edgeCnt;
    logic              r_finish;
    logic              r_busy;
    logic              r_done;
    logic              r_sclk;
    logic              r_mosi;
    logic [DATA_W-1:0] r_rxData;
    logic [NUM_CS-1:0] r_csN;

    logic              w_tick;
    logic              w_accept;
    logic              w_cpha;
    logic              w_lastEdge;
    logic              w_doEdge;
    logic              w_sample;
    logic              w_shiftOut;
    logic              w_txFirst;
    logic              w_mosiNext;
    logic [EW-1:0]     w_nextEdge;
    logic [DATA_W-1:0] w_txNext;
    logic [DATA_W-1:0] w_rxNext;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clkDiv (
        .clk     (clk),
        .reset   (reset),
        .i_enable(r_state != IDLE),
        .o_tick  (w_tick)
    );

    // Edge bookkeeping: edges are numbered from 1, odd edges are the leading ones.
    always_comb begin
        w_accept   = start && (int'(cs_sel) < NUM_CS);
        w_cpha     = modeCpha(r_mode);
        w_nextEdge = r_edgeCnt + EW'(1);
        w_lastEdge = (r_edgeCnt == EW'(EDGES));
        w_doEdge   = w_tick && ((r_state == SETUP) || (r_state == SHIFT && !w_lastEdge));
        w_sample   = w_cpha ? !w_nextEdge[0] : w_nextEdge[0];
        w_shiftOut = w_cpha ? (w_nextEdge[0] && (w_nextEdge != EW'(1)))
                            : (!w_nextEdge[0] && (w_nextEdge != EW'(EDGES)));
        if (LSB_FIRST != 0) begin
            w_txFirst  = tx_data[0];
            w_txNext   = r_txShift >> 1;
            w_mosiNext = r_txShift[1];
            w_rxNext   = {miso, r_rxShift[DATA_W-1:1]};
        end else begin
            w_txFirst  = tx_data[DATA_W-1];
            w_txNext   = r_txShift << 1;
            w_mosiNext = r_txShift[DATA_W-2];
            w_rxNext   = {r_rxShift[DATA_W-2:0], miso};
        end
    end

    // r_finish marks the IDLE cycle between HOLD and the done pulse; start is refused there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mode    <= MODE0;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_edgeCnt <= '0;
            r_finish  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_rxData  <= '0;
            r_csN     <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sclk <= mode[1];
                    r_mosi <= 1'b0;
                    if (r_finish) begin
                        r_finish <= 1'b0;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_csN    <= '1;
                        r_rxData <= r_rxShift;
                    end else if (w_accept) begin
                        r_state   <= SETUP;
                        r_mode    <= mode;
                        r_txShift <= tx_data;
                        r_rxShift <= '0;
                        r_edgeCnt <= '0;
                        r_busy    <= 1'b1;
                        r_csN     <= ~(NUM_CS'(1) << cs_sel);
                        r_mosi    <= w_txFirst;
                    end
                end
                SETUP: begin
                    if (w_tick) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_tick && w_lastEdge) r_state <= HOLD;
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state  <= IDLE;
                        r_finish <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_doEdge) begin
                r_sclk    <= ~r_sclk;
                r_edgeCnt <= w_nextEdge;
                if (w_sample) r_rxShift <= w_rxNext;
                if (w_shiftOut) begin
                    r_txShift <= w_txNext;
                    r_mosi    <= w_mosiNext;
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rxData;
    assign sclk    = r_sclk;
    assign cs_n    = r_csN;
    assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: table plus random transfers against a behavioural SPI slave.
module tb_spi_master_gen;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: 8-bit, CLK_DIV=2, four selects, LSB first.
    logic       startA, loopA, slaveBitA, misoA;
    logic [1:0] modeA, csSelA;
    logic [7:0] txA, rxA;
    logic       busyA, doneA, sclkA, mosiA;
    logic [3:0] csnA;
    assign misoA = loopA ? mosiA : slaveBitA;

    spi_master_gen #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .LSB_FIRST(1)) dutA (
        .clk(clk), .reset(reset), .start(startA), .mode(modeA), .cs_sel(csSelA),
        .tx_data(txA), .busy(busyA), .done(doneA), .rx_data(rxA), .sclk(sclkA),
        .cs_n(csnA), .mosi(mosiA), .miso(misoA));

    // Instance B: 16-bit, CLK_DIV=1, MSB first, miso looped back.
    logic        startB, misoB;
    logic [1:0]  modeB;
    logic [0:0]  csSelB;
    logic [15:0] txB, rxB;
    logic        busyB, doneB, sclkB, mosiB;
    logic [0:0]  csnB;
    assign misoB = mosiB;

    spi_master_gen #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1), .LSB_FIRST(0)) dutB (
        .clk(clk), .reset(reset), .start(startB), .mode(modeB), .cs_sel(csSelB),
        .tx_data(txB), .busy(busyB), .done(doneB), .rx_data(rxB), .sclk(sclkB),
        .cs_n(csnB), .mosi(mosiB), .miso(misoB));

    // Instance C: three selects, so an out-of-range cs_sel is representable.
    logic       startC, misoC;
    logic [1:0] modeC, csSelC;
    logic [3:0] txC, rxC;
    logic       busyC, doneC, sclkC, mosiC;
    logic [2:0] csnC;
    assign misoC = 1'b1;

    spi_master_gen #(.DATA_W(4), .CLK_DIV(1), .NUM_CS(3), .LSB_FIRST(1)) dutC (
        .clk(clk), .reset(reset), .start(startC), .mode(modeC), .cs_sel(csSelC),
        .tx_data(txC), .busy(busyC), .done(doneC), .rx_data(rxC), .sclk(sclkC),
        .cs_n(csnC), .mosi(mosiC), .miso(misoC));

    typedef struct {
        logic [7:0] tx;
        logic [1:0] mode;
        logic [1:0] cs;
        logic [7:0] slave;
        bit         loop;
        logic [7:0] expRx;
    } vecA_t;

    vecA_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one transfer on A acting as the slave; returns in the done cycle.
    task automatic applyStimulus(input vecA_t v);
        int         edges, samples, csErr, lat, t0, idx;
        logic       prevS;
        logic [7:0] mosiWord;
        bit         cpha;
        logic [3:0] expCs;
        cpha  = v.mode[0];
        expCs = ~(4'b0001 << v.cs);
        @(posedge clk); #1;
        modeA = v.mode; txA = v.tx; csSelA = v.cs; loopA = v.loop; slaveBitA = v.slave[0];
        @(posedge clk); #1;
        checkOutput("idle_sclk", 32'(sclkA), 32'(v.mode[1]));
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        t0 = cyc; prevS = sclkA; edges = 0; samples = 0; csErr = 0; lat = -1; mosiWord = '0;
        for (int c = 0; c < 200; c++) begin
            if (busyA && (csnA !== expCs)) csErr++;
            if (sclkA !== prevS) begin
                prevS = sclkA;
                edges++;
                if ((cpha ? (edges % 2 == 0) : (edges % 2 == 1)) && samples < 8) begin
                    mosiWord[samples] = mosiA;
                    samples++;
                end
                idx = cpha ? (edges - 1) / 2 : edges / 2;
                if (idx > 7) idx = 7;
                slaveBitA = v.slave[idx];
            end
            if (c == 3) begin
                txA = ~v.tx; modeA = ~v.mode; csSelA = v.cs + 2'd1; startA = 1'b1;
            end
            if (c == 4) startA = 1'b0;
            @(posedge clk); #1;
            if (doneA) begin
                lat = cyc - t0;
                break;
            end
        end
        checkOutput("done_latency", lat, 37);
        checkOutput("rx_data", 32'(rxA), 32'(v.expRx));
        checkOutput("mosi_bits", 32'(mosiWord), 32'(v.tx));
        checkOutput("sclk_edges", edges, 16);
        checkOutput("cs_during_xfer", csErr, 0);
        checkOutput("done_busy", 32'(busyA), 0);
        checkOutput("done_csn", 32'(csnA), 32'hF);
    endtask

    initial begin
        vecA_t      r;
        int         lat, t0, edges, first, last, seen, csErr;
        logic       prev;
        logic [15:0] word;

        reset = 1'b1;
        startA = 0; loopA = 0; slaveBitA = 0; modeA = 0; csSelA = 0; txA = 0;
        startB = 0; modeB = 0; csSelB = 0; txB = 0;
        startC = 0; modeC = 0; csSelC = 0; txC = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busyA), 0);
        checkOutput("reset_done", 32'(doneA), 0);
        checkOutput("reset_csn", 32'(csnA), 32'hF);
        checkOutput("reset_rx", 32'(rxA), 0);
        reset = 1'b0;

        vecs.push_back('{tx: 8'hA5, mode: 2'd0, cs: 2'd0, slave: 8'h00, loop: 1'b1, expRx: 8'hA5});
        for (int m = 0; m < 4; m++)
            vecs.push_back('{tx: 8'h3C, mode: 2'(m), cs: 2'd2, slave: 8'hC3, loop: 1'b0, expRx: 8'hC3});
        for (int i = 0; i < 6; i++) begin
            r.tx = 8'($urandom); r.slave = 8'($urandom);
            r.mode = 2'($urandom_range(0, 3)); r.cs = 2'($urandom_range(0, 3));
            r.loop = 1'b0; r.expRx = r.slave;
            vecs.push_back(r);
        end
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk); #1;
            checkOutput("done_pulse_width", 32'(doneA), 0);
            checkOutput("rx_hold", 32'(rxA), 32'(vecs[i].expRx));
        end

        // Back-to-back: new start in the done cycle, later starts while busy are dropped.
        applyStimulus('{tx: 8'h11, mode: 2'd0, cs: 2'd1, slave: 8'h77, loop: 1'b0, expRx: 8'h77});
        modeA = 2'd0; txA = 8'h5A; csSelA = 2'd1; loopA = 1'b1; startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        t0 = cyc; lat = -1; csErr = 0;
        checkOutput("b2b_busy", 32'(busyA), 1);
        checkOutput("b2b_csn", 32'(csnA), 32'hD);
        for (int c = 0; c < 200; c++) begin
            if (c == 1) begin startA = 1'b1; csSelA = 2'd3; txA = 8'hFF; end
            if (c == 3) startA = 1'b0;
            if (busyA && (csnA !== 4'hD)) csErr++;
            @(posedge clk); #1;
            if (doneA) begin lat = cyc - t0; break; end
        end
        checkOutput("b2b_latency", lat, 37);
        checkOutput("b2b_rx", 32'(rxA), 32'h5A);
        checkOutput("busy_start_ignored_cs", csErr, 0);
        @(posedge clk); #1;
        checkOutput("busy_start_not_queued", 32'(busyA), 0);

        // Abort at the fifth sclk edge.
        modeA = 2'd0; txA = 8'h96; csSelA = 2'd3; loopA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        prev = sclkA; edges = 0;
        for (int c = 0; c < 100 && edges < 5; c++) begin
            @(posedge clk); #1;
            if (sclkA !== prev) begin prev = sclkA; edges++; end
        end
        checkOutput("abort_reached_edge5", edges, 5);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busyA), 0);
        checkOutput("abort_done", 32'(doneA), 0);
        checkOutput("abort_csn", 32'(csnA), 32'hF);
        checkOutput("abort_sclk", 32'(sclkA), 0);
        checkOutput("abort_mosi", 32'(mosiA), 0);
        checkOutput("abort_rx", 32'(rxA), 0);
        #2 reset = 1'b0;
        seen = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (doneA || busyA) seen++;
        end
        checkOutput("abort_no_done", seen, 0);

        // Out-of-range select refused, then a valid one on instance C.
        modeC = 2'd0; txC = 4'hF; csSelC = 2'd3;
        @(posedge clk); #1;
        startC = 1'b1;
        @(posedge clk); #1;
        startC = 1'b0;
        checkOutput("bad_sel_busy", 32'(busyC), 0);
        checkOutput("bad_sel_csn", 32'(csnC), 32'h7);
        @(posedge clk); #1;
        checkOutput("bad_sel_busy_later", 32'(busyC), 0);
        csSelC = 2'd2; startC = 1'b1;
        @(posedge clk); #1;
        startC = 1'b0;
        t0 = cyc; lat = -1;
        checkOutput("sel2_busy", 32'(busyC), 1);
        checkOutput("sel2_csn", 32'(csnC), 32'h3);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (doneC) begin lat = cyc - t0; break; end
        end
        checkOutput("c_latency", lat, 11);
        checkOutput("c_rx", 32'(rxC), 32'hF);

        // 16-bit MSB-first transfer at sclk = clk/2.
        modeB = 2'd0; txB = 16'h8001;
        @(posedge clk); #1;
        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        t0 = cyc; prev = sclkB; edges = 0; word = '0; first = -1; last = -1; lat = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (doneB) begin lat = cyc - t0; break; end
            if (sclkB !== prev) begin
                prev = sclkB;
                edges++;
                if (first < 0) first = cyc;
                last = cyc;
                if (sclkB) word = {word[14:0], mosiB};
            end
        end
        checkOutput("b_latency", lat, 35);
        checkOutput("b_edges", edges, 32);
        checkOutput("b_edge_span", last - first, 31);
        checkOutput("b_mosi_msb_first", 32'(word), 32'h8001);
        checkOutput("b_rx", 32'(rxB), 32'h8001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
